// File: rtl/frame_cropper_pkg.sv
// Shared types and helpers for the frame cropper: pixel position struct and
// output-resolution calculation.
package frame_cropper_pkg;

    localparam int unsigned POS_W = 16;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

    function automatic pos_t crop_res(input int unsigned res_x, input int unsigned res_y,
                                      input int unsigned left, input int unsigned right,
                                      input int unsigned top, input int unsigned bottom);
        pos_t r;
        r.x = POS_W'(res_x - left - right);
        r.y = POS_W'(res_y - top - bottom);
        return r;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream video bundle: tuser = start of frame, tlast = end of line.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    localparam int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;

    modport master (output tvalid, output tdata, output tuser, output tlast,
                    output tkeep, output tstrb, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/frame_pos_cnt.sv
// Input pixel position tracker: saturating x/y counters that restart on tuser,
// plus a sync flag that is set by the first tuser after reset.
module frame_pos_cnt
    import frame_cropper_pkg::*;
#(
    parameter int unsigned FRAME_RES_X = 1924,
    parameter int unsigned FRAME_RES_Y = 1084
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hs_i,
    input  logic tuser_i,
    input  logic tlast_i,
    output pos_t pos_o,
    output logic sync_o
);
    localparam int unsigned XW = $clog2(FRAME_RES_X);
    localparam int unsigned YW = $clog2(FRAME_RES_Y);
    localparam logic [XW-1:0] X_MAX = XW'(FRAME_RES_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FRAME_RES_Y - 1);

    logic [XW-1:0] x_cnt_q, x_cnt_d, cur_x;
    logic [YW-1:0] y_cnt_q, y_cnt_d, cur_y;
    logic          sync_q, sync_d;

    // A tuser pixel is position (0,0) regardless of where the counters were.
    assign cur_x = tuser_i ? '0 : x_cnt_q;
    assign cur_y = tuser_i ? '0 : y_cnt_q;

    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        sync_d  = sync_q;
        if (hs_i) begin
            if (tuser_i) begin
                sync_d = 1'b1;
            end
            if (tlast_i) begin
                x_cnt_d = '0;
                y_cnt_d = (cur_y == Y_MAX) ? Y_MAX : cur_y + 1'b1;
            end else begin
                x_cnt_d = (cur_x == X_MAX) ? X_MAX : cur_x + 1'b1;
                y_cnt_d = cur_y;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            sync_q  <= 1'b0;
        end else begin
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            sync_q  <= sync_d;
        end
    end

    assign pos_o.x = POS_W'(x_cnt_q);
    assign pos_o.y = POS_W'(y_cnt_q);
    assign sync_o  = sync_q;

endmodule

// File: rtl/frame_cropper.sv
// Crops a fixed border from an AXI4-Stream frame and regenerates tuser/tlast.
// Optional stream-format checking (line_err_o/frame_err_o) with FRAME_CROPPER_CHECK_EN.
module frame_cropper
    import frame_cropper_pkg::*;
#(
    parameter int unsigned PX_WIDTH    = 8,
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned FRAME_RES_X = 1924,
    parameter int unsigned FRAME_RES_Y = 1084,
    parameter int unsigned TOP         = 2,
    parameter int unsigned BOTTOM      = 2,
    parameter int unsigned LEFT        = 2,
    parameter int unsigned RIGHT       = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o
`ifdef FRAME_CROPPER_CHECK_EN
    ,
    output logic          line_err_o,
    output logic          frame_err_o
`endif
);
    if (LEFT + RIGHT >= FRAME_RES_X || TOP + BOTTOM >= FRAME_RES_Y) begin : g_bad_crop
        $fatal(1, "frame_cropper: border leaves no pixels");
    end
    if (TDATA_WIDTH < PX_WIDTH) begin : g_bad_width
        $fatal(1, "frame_cropper: TDATA_WIDTH narrower than PX_WIDTH");
    end

    localparam pos_t OUT_RES = crop_res(FRAME_RES_X, FRAME_RES_Y, LEFT, RIGHT, TOP, BOTTOM);
    localparam logic [POS_W-1:0] X_LO = POS_W'(LEFT);
    localparam logic [POS_W-1:0] Y_LO = POS_W'(TOP);
    localparam logic [POS_W-1:0] X_HI = POS_W'(LEFT + int'(OUT_RES.x) - 1);
    localparam logic [POS_W-1:0] Y_HI = POS_W'(TOP + int'(OUT_RES.y) - 1);

    pos_t cnt, cur;
    logic sync_q, synced;
    logic in_ready, in_hs, keep;

    logic                   out_valid_q, out_valid_d;
    logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_user_q, out_user_d;
    logic                   out_last_q, out_last_d;

    assign in_ready = video_o.tready || !out_valid_q;
    assign in_hs    = video_i.tvalid && in_ready;

    frame_pos_cnt #(
        .FRAME_RES_X (FRAME_RES_X),
        .FRAME_RES_Y (FRAME_RES_Y)
    ) u_pos_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hs_i    (in_hs),
        .tuser_i (video_i.tuser),
        .tlast_i (video_i.tlast),
        .pos_o   (cnt),
        .sync_o  (sync_q)
    );

    assign cur    = video_i.tuser ? '0 : cnt;
    assign synced = sync_q || video_i.tuser;
    assign keep   = in_hs && synced && (cur.x >= X_LO) && (cur.x <= X_HI)
                    && (cur.y >= Y_LO) && (cur.y <= Y_HI);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        if (keep) begin
            out_valid_d = 1'b1;
            out_data_d  = video_i.tdata;
            out_user_d  = (cur.x == X_LO) && (cur.y == Y_LO);
            out_last_d  = (cur.x == X_HI);
        end else if (video_o.tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
        end
    end

    assign video_i.tready = in_ready;
    assign video_o.tvalid = out_valid_q;
    assign video_o.tdata  = out_data_q;
    assign video_o.tuser  = out_user_q;
    assign video_o.tlast  = out_last_q;
    assign video_o.tkeep  = '1;
    assign video_o.tstrb  = '1;

`ifdef FRAME_CROPPER_CHECK_EN
    localparam logic [POS_W-1:0] X_END = POS_W'(FRAME_RES_X - 1);
    localparam logic [POS_W-1:0] Y_END = POS_W'(FRAME_RES_Y - 1);

    logic line_err_q, line_err_d;
    logic frame_err_q, frame_err_d;

    always_comb begin
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        if (in_hs) begin
            if (video_i.tlast != (cur.x == X_END)) begin
                line_err_d = 1'b1;
            end
            // sync_q is still clear for the first tuser after reset
            if (video_i.tuser && sync_q && (cnt.y != Y_END || cnt.x != '0)) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign line_err_o  = line_err_q;
    assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_frame_cropper.sv
// Bench for frame_cropper: three 8x6 instances (1-pixel border, no border, asymmetric),
// a cycle-level vector table plus randomised frames checked against a queue model.
module tb_frame_cropper;

    localparam int RX = 8;
    localparam int RY = 6;

    int cl[3] = '{1, 0, 2};
    int cr[3] = '{1, 0, 0};
    int ct[3] = '{1, 0, 0};
    int cb[3] = '{1, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = '0;
    logic       src_user = 1'b0;
    logic       src_last = 1'b0;
    logic       out_ready = 1'b1;
    int         sel = 0;

    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_WIDTH(8)) in_a ();
    axi4_stream_if #(.DATA_WIDTH(8)) out_a ();
    axi4_stream_if #(.DATA_WIDTH(8)) in_b ();
    axi4_stream_if #(.DATA_WIDTH(8)) out_b ();
    axi4_stream_if #(.DATA_WIDTH(8)) in_c ();
    axi4_stream_if #(.DATA_WIDTH(8)) out_c ();

    assign in_a.tvalid = src_valid && (sel == 0);
    assign in_b.tvalid = src_valid && (sel == 1);
    assign in_c.tvalid = src_valid && (sel == 2);
    assign in_a.tdata  = src_data;
    assign in_b.tdata  = src_data;
    assign in_c.tdata  = src_data;
    assign in_a.tuser  = src_user;
    assign in_b.tuser  = src_user;
    assign in_c.tuser  = src_user;
    assign in_a.tlast  = src_last;
    assign in_b.tlast  = src_last;
    assign in_c.tlast  = src_last;
    assign in_a.tkeep  = '1;
    assign in_b.tkeep  = '1;
    assign in_c.tkeep  = '1;
    assign in_a.tstrb  = '1;
    assign in_b.tstrb  = '1;
    assign in_c.tstrb  = '1;
    assign out_a.tready = out_ready;
    assign out_b.tready = out_ready;
    assign out_c.tready = out_ready;

`ifdef FRAME_CROPPER_CHECK_EN
    logic lerr_a, ferr_a, lerr_b, ferr_b, lerr_c, ferr_c;
`endif

    frame_cropper #(.PX_WIDTH(8), .TDATA_WIDTH(8), .FRAME_RES_X(RX), .FRAME_RES_Y(RY),
                    .TOP(1), .BOTTOM(1), .LEFT(1), .RIGHT(1)) dut_a (
        .clk_i (clk), .rst_i (rst), .video_i (in_a), .video_o (out_a)
`ifdef FRAME_CROPPER_CHECK_EN
        , .line_err_o (lerr_a), .frame_err_o (ferr_a)
`endif
    );
    frame_cropper #(.PX_WIDTH(8), .TDATA_WIDTH(8), .FRAME_RES_X(RX), .FRAME_RES_Y(RY),
                    .TOP(0), .BOTTOM(0), .LEFT(0), .RIGHT(0)) dut_b (
        .clk_i (clk), .rst_i (rst), .video_i (in_b), .video_o (out_b)
`ifdef FRAME_CROPPER_CHECK_EN
        , .line_err_o (lerr_b), .frame_err_o (ferr_b)
`endif
    );
    frame_cropper #(.PX_WIDTH(8), .TDATA_WIDTH(8), .FRAME_RES_X(RX), .FRAME_RES_Y(RY),
                    .TOP(0), .BOTTOM(3), .LEFT(2), .RIGHT(0)) dut_c (
        .clk_i (clk), .rst_i (rst), .video_i (in_c), .video_o (out_c)
`ifdef FRAME_CROPPER_CHECK_EN
        , .line_err_o (lerr_c), .frame_err_o (ferr_c)
`endif
    );

    logic       ov, ou, ol, okeep, src_ready;
    logic [7:0] od;

    always_comb begin
        ov = out_a.tvalid; od = out_a.tdata; ou = out_a.tuser; ol = out_a.tlast;
        okeep = out_a.tkeep[0] & out_a.tstrb[0]; src_ready = in_a.tready;
        if (sel == 1) begin
            ov = out_b.tvalid; od = out_b.tdata; ou = out_b.tuser; ol = out_b.tlast;
            okeep = out_b.tkeep[0] & out_b.tstrb[0]; src_ready = in_b.tready;
        end else if (sel == 2) begin
            ov = out_c.tvalid; od = out_c.tdata; ou = out_c.tuser; ol = out_c.tlast;
            okeep = out_c.tkeep[0] & out_c.tstrb[0]; src_ready = in_c.tready;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected output beats in order.
    typedef struct { logic [7:0] d; bit u; bit l; } beat_t;
    beat_t exp_q[$];
    bit    m_sync = 1'b0;
    bit    mon_en = 1'b0;
    bit    bp = 1'b0;
    bit    gaps = 1'b0;
    int    beats = 0;

    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_u, prev_l;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else if (mon_en) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(ov), 32'd1);
                chk("stall_data", 32'(od), 32'(prev_d));
                chk("stall_user", 32'(ou), 32'(prev_u));
                chk("stall_last", 32'(ol), 32'(prev_l));
            end
            if (ov && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h, expected no beat", od);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(od), 32'(e.d));
                    chk("beat_user", 32'(ou), 32'(e.u));
                    chk("beat_last", 32'(ol), 32'(e.l));
                end
            end
            prev_stall = ov && !out_ready;
            prev_d = od;
            prev_u = ou;
            prev_l = ol;
        end
    end

    task automatic tick();
        @(negedge clk);
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(negedge clk);
            out_ready = 1'b1;
            src_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        src_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        sel = s;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_sync = 1'b0;
        beats = 0;
        #1;
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", 32'(od), 32'd0);
        chk("rst_user", 32'(ou), 32'd0);
        chk("rst_last", 32'(ol), 32'd0);
        chk("keep_strb", 32'(okeep), 32'd1);
    endtask

    task automatic send_px(input logic [7:0] d, input bit u, input bit l,
                           input bit keep, input bit eu, input bit el);
        int w;
        beat_t b;
        w = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            tick();
            src_valid = 1'b0;
        end
        do begin
            tick();
            src_valid = 1'b1;
            src_data  = d;
            src_user  = u;
            src_last  = l;
            #1;
            w++;
        end while (!src_ready && w < 200);
        if (!src_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", w);
        end
        if (keep) begin
            b.d = d;
            b.u = eu;
            b.l = el;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_line(input int y, input int len, input bit sof, input bit eol);
        bit u, l, k;
        logic [7:0] d;
        for (int x = 0; x < len; x++) begin
            u = sof && (x == 0);
            l = eol && (x == len - 1);
            d = 8'($urandom_range(0, 255));
            if (u) m_sync = 1'b1;
            k = m_sync && x >= cl[sel] && x <= RX - cr[sel] - 1
                && y >= ct[sel] && y <= RY - cb[sel] - 1;
            send_px(d, u, l, k, (x == cl[sel]) && (y == ct[sel]), x == RX - cr[sel] - 1);
        end
    endtask

    // short_y: line ended early at x=5; trunc_y: frame abandoned mid-line trunc_y.
    task automatic send_frame(input int short_y, input int trunc_y, input int trunc_len);
        for (int y = 0; y < RY; y++) begin
            if (y == trunc_y) begin
                send_line(y, trunc_len, y == 0, 1'b0);
                return;
            end
            send_line(y, (y == short_y) ? 6 : RX, y == 0, 1'b1);
        end
    endtask

    typedef struct {
        bit vld; logic [7:0] d; bit u; bit l; bit ordy;
        bit e_ov; logic [7:0] e_d; bit e_u; bit e_l; bit e_ir; bit chkd;
    } vec_t;
    vec_t vecs[17];

    initial begin
        // Cycle-level vectors on the zero-border instance (output = input, 1 cycle later).
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int x = 0; x < 8; x++) begin
            vecs[7 + x] = '{1'b1, 8'(8'h50 + x), 1'b0, x == 7, 1'b1,
                            1'b1, 8'(8'h50 + x), 1'b0, x == 7, 1'b1, 1'b1};
        end
        vecs[15] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1};

        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            src_valid = vecs[i].vld;
            src_data  = vecs[i].d;
            src_user  = vecs[i].u;
            src_last  = vecs[i].l;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(ov), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(src_ready), 32'(vecs[i].e_ir));
            if (vecs[i].chkd) begin
                chk($sformatf("vec%0d_data", i), 32'(od), 32'(vecs[i].e_d));
                chk($sformatf("vec%0d_user", i), 32'(ou), 32'(vecs[i].e_u));
                chk($sformatf("vec%0d_last", i), 32'(ol), 32'(vecs[i].e_l));
            end
        end

        // 1-pixel border, always ready: 6x4 = 24 beats per frame.
        do_reset(0);
        mon_en = 1'b1;
        repeat (3) send_frame(-1, -1, 0);
        drain(5);
        chk("beats_3frames", 32'(beats), 32'd72);

        // Random backpressure and input gaps.
        bp = 1'b1;
        gaps = 1'b1;
        repeat (2) send_frame(-1, -1, 0);
        drain(10);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Resync: new tuser arrives in input line 3.
        send_frame(-1, 3, 4);
        send_frame(-1, -1, 0);
        drain(10);
        chk("resync_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef FRAME_CROPPER_CHECK_EN
        chk("frame_err_resync", 32'(ferr_a), 32'd1);
        chk("line_err_before_short", 32'(lerr_a), 32'd0);
`endif

        // Short line: tlast at x=5 in line 2.
        send_frame(2, -1, 0);
        send_frame(-1, -1, 0);
        drain(10);
        chk("short_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef FRAME_CROPPER_CHECK_EN
        chk("line_err_short", 32'(lerr_a), 32'd1);
        drain(5);
        chk("line_err_sticky", 32'(lerr_a), 32'd1);
`endif

        // Reset mid-frame, then a line without tuser must be ignored.
        send_frame(-1, 2, 5);
        do_reset(0);
`ifdef FRAME_CROPPER_CHECK_EN
        chk("line_err_cleared", 32'(lerr_a), 32'd0);
`endif
        send_line(0, RX, 1'b0, 1'b1);
        drain(3);
        chk("unsynced_beats", 32'(beats), 32'd0);
        send_frame(-1, -1, 0);
        drain(10);
        chk("after_reset_beats", 32'(beats), 32'd24);
        chk("after_reset_queue", 32'(exp_q.size()), 32'd0);

        // Zero border under backpressure.
        do_reset(1);
        repeat (2) send_frame(-1, -1, 0);
        drain(10);
        chk("zero_border_beats", 32'(beats), 32'd96);
        chk("zero_border_queue", 32'(exp_q.size()), 32'd0);

        // Asymmetric crop: 6x3 starting at input (2,0).
        do_reset(2);
        repeat (2) send_frame(-1, -1, 0);
        drain(10);
        chk("asym_beats", 32'(beats), 32'd36);
        chk("asym_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
